// File: rtl/audio_serializer_pkg.sv
// audio_serializer_pkg: shared state type, default sizing and counter-width helper.
package audio_serializer_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_CLKS_PER_BIT = 65;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/audio_serializer_bit_timer.sv
// audio_serializer_bit_timer: CLKS_PER_BIT prescaler with sync clear; tick is high on the terminal-count cycle.
module audio_serializer_bit_timer
  import audio_serializer_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic run,
  output logic tick,
  output logic tick_d
);
  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic tick_q;
  // tick_d is exposed so the parent can register done in the same cycle as tick
  always_comb begin
    cnt_d = (clr || tick_q) ? '0 : cnt_q + 1'b1;
    tick_d = run && (cnt_d == LAST);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tick_q <= tick_d;
    end
  end
  assign tick = tick_q;
endmodule

// File: rtl/audio_serializer.sv
// audio_serializer: parallel-to-serial audio shifter, MSB first (LSB first with SERIALIZER_LSB_FIRST_EN).
module audio_serializer
  import audio_serializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in,
  output logic             done,
  output logic             audio_data,
  output logic             audio_enable
);
  localparam int BW = cnt_w(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  state_t state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic done_q, done_d, audio_data_q, audio_data_d, audio_enable_q, audio_enable_d;
  logic load, tick, tick_d, timer_clr;
  audio_serializer_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clr    (timer_clr),
    .run    (enable),
    .tick   (tick),
    .tick_d (tick_d)
  );
  // enable alone decides the next state: it keeps, reloads, or aborts a frame
  always_comb begin
    state_d = enable ? SHIFT : IDLE;
    load = enable && (state_q == IDLE || (tick && bit_cnt_q == '0));
    timer_clr = !(enable && state_q == SHIFT);
    bit_cnt_d = !enable ? '0 : load ? LAST_BIT : tick ? bit_cnt_q - 1'b1 : bit_cnt_q;
`ifdef SERIALIZER_LSB_FIRST_EN
    shift_d = !enable ? '0 : load ? data_in : tick ? shift_q >> 1 : shift_q;
    audio_data_d = enable && shift_d[0];
`else
    shift_d = !enable ? '0 : load ? data_in : tick ? shift_q << 1 : shift_q;
    audio_data_d = enable && shift_d[WIDTH-1];
`endif
    audio_enable_d = enable;
    done_d = enable && tick_d && bit_cnt_d == '0;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_cnt_q <= '0;
      done_q <= 1'b0;
      audio_data_q <= 1'b0;
      audio_enable_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      done_q <= done_d;
      audio_data_q <= audio_data_d;
      audio_enable_q <= audio_enable_d;
    end
  end
  assign done = done_q;
  assign audio_data = audio_data_q;
  assign audio_enable = audio_enable_q;
endmodule

// File: tb/tb_audio_serializer.sv
// tb_audio_serializer: checks two serializers (CLKS_PER_BIT 4 and 1) against a frame-position reference model.
module tb_audio_serializer;
  localparam int W = 16;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] en = '0;
  logic [1:0] done, ad, ae;
  logic [W-1:0] din [2];
  int vectors = 0;
  int miscompares = 0;
  int cpb [2] = '{4, 1};
  bit act [2];
  int k [2];
  logic [W-1:0] fd [2];

  always #5 clock = ~clock;

  audio_serializer #(.WIDTH(W), .CLKS_PER_BIT(4)) dut_a (
    .clock(clock), .reset_n(reset_n), .enable(en[0]), .data_in(din[0]),
    .done(done[0]), .audio_data(ad[0]), .audio_enable(ae[0])
  );
  audio_serializer #(.WIDTH(W), .CLKS_PER_BIT(1)) dut_b (
    .clock(clock), .reset_n(reset_n), .enable(en[1]), .data_in(din[1]),
    .done(done[1]), .audio_data(ad[1]), .audio_enable(ae[1])
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input int i);
    int idx;
    idx = k[i] / cpb[i];
`ifdef SERIALIZER_LSB_FIRST_EN
    return fd[i][idx];
`else
    return fd[i][W-1-idx];
`endif
  endfunction

  // model: a frame is a position k in 0..W*CPB-1; bit index is k/CPB
  task automatic step();
    @(posedge clock);
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) act[i] = 0;
      else if (!act[i]) begin
        if (en[i]) begin act[i] = 1; k[i] = 0; fd[i] = din[i]; end
      end else if (!en[i]) act[i] = 0;
      else if (k[i] == W * cpb[i] - 1) begin k[i] = 0; fd[i] = din[i]; end
      else k[i]++;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk(i == 0 ? "audio_enable_a" : "audio_enable_b", ae[i], act[i]);
      chk(i == 0 ? "audio_data_a" : "audio_data_b", ad[i], act[i] ? exp_bit(i) : 1'b0);
      chk(i == 0 ? "done_a" : "done_b", done[i], act[i] && k[i] == W * cpb[i] - 1);
    end
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  initial begin
    din[0] = 16'h8001;
    din[1] = 16'h8001;
    en = 2'b11;
    steps(3);
    en = 2'b00;
    reset_n = 1'b1;
    steps(2);
    en[0] = 1'b1;
    steps(64);
    en[0] = 1'b0;
    steps(4);
    din[0] = 16'hA5A5;
    en[0] = 1'b1;
    steps(30);
    din[0] = 16'h0F0F;
    steps(34 + 64);
    en[0] = 1'b0;
    steps(2);
    din[0] = 16'hFFFF;
    en[0] = 1'b1;
    steps(21);
    en[0] = 1'b0;
    steps(3);
    din[0] = 16'h8001;
    en[0] = 1'b1;
    steps(10);
    en[0] = 1'b0;
    steps(2);
    din[1] = 16'h1234;
    en[1] = 1'b1;
    steps(16);
    en[1] = 1'b0;
    steps(2);
    din[1] = 16'h8001;
    en[1] = 1'b1;
    steps(16);
    din[1] = 16'h0003;
    steps(16);
    en[1] = 1'b0;
    steps(2);
    en = 2'b11;
    din[0] = 16'hC3C3;
    din[1] = 16'hFFFF;
    steps(7);
    #3 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("async_reset_enable", ae[i], 1'b0);
      chk("async_reset_data", ad[i], 1'b0);
      chk("async_reset_done", done[i], 1'b0);
    end
    steps(2);
    reset_n = 1'b1;
    steps(3);
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 39) == 0) en[i] = ~en[i];
        if ($urandom_range(0, 9) == 0) din[i] = W'($urandom);
      end
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
